// File: rtl/motor_pkg.sv
// Shared types, default parameters and helpers for the PWM motor driver.
package motor_pkg;

    localparam int unsigned PWM_RESOLUTION_DEF  = 17;
    localparam int unsigned CONTROL_WIDTH_DEF   = PWM_RESOLUTION_DEF + 1;
    localparam int unsigned DEADTIME_CYCLES_DEF = 256;

    // Working width of the saturation helper; callers sign-extend into it.
    localparam int unsigned SAT_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2,
        WAIT = 2'd3
    } pwm_state_t;

    // Magnitude of a signed value, clamped to 2**res_bits-1 (res_bits < SAT_W).
    function automatic logic [SAT_W-1:0] sat_abs(input logic signed [SAT_W-1:0] value,
                                                 input int unsigned            res_bits);
        logic [SAT_W-1:0] mag;
        logic [SAT_W-1:0] limit;
        mag   = value[SAT_W-1] ? SAT_W'(-value) : SAT_W'(value);
        limit = (SAT_W'(1) << res_bits) - SAT_W'(1);
        return (mag > limit) ? limit : mag;
    endfunction

endpackage

// File: rtl/pwm_motor_driver_if.sv
// Command/status bundle between the control source and the PWM motor driver.
interface pwm_motor_driver_if
    import motor_pkg::*;
#(
    parameter int unsigned PWM_RESOLUTION = PWM_RESOLUTION_DEF,
    parameter int unsigned CONTROL_WIDTH  = PWM_RESOLUTION + 1
);

    logic                             en;
    logic                             control_valid;
    logic signed [CONTROL_WIDTH-1:0]  control_in;
    logic                             pwm_out;
    logic                             dir_out;
    logic                             period_start;
    logic                             dead_active;
    logic        [PWM_RESOLUTION-1:0] duty_active;

    modport master (
        output en, control_valid, control_in,
        input  pwm_out, dir_out, period_start, dead_active, duty_active
    );

    modport slave (
        input  en, control_valid, control_in,
        output pwm_out, dir_out, period_start, dead_active, duty_active
    );

endinterface

// File: rtl/pwm_motor_driver.sv
// Signed control word -> PWM + direction, with dead time on every reversal.
// Duty is double-buffered through shadow registers and applied at period boundaries.
module pwm_motor_driver
    import motor_pkg::*;
#(
    parameter int unsigned PWM_RESOLUTION  = PWM_RESOLUTION_DEF,
    parameter int unsigned CONTROL_WIDTH   = CONTROL_WIDTH_DEF,
    parameter int unsigned DEADTIME_CYCLES = DEADTIME_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    pwm_motor_driver_if.slave bus
);

    localparam int unsigned       DEAD_W    = (DEADTIME_CYCLES > 1) ? $clog2(DEADTIME_CYCLES) : 1;
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEADTIME_CYCLES - 1);

    logic signed [CONTROL_WIDTH-1:0]  ctrl_in;

    pwm_state_t                       state_q,        state_d;
    logic        [PWM_RESOLUTION-1:0] cnt_q,          cnt_d;
    logic        [DEAD_W-1:0]         dead_cnt_q,     dead_cnt_d;
    logic        [PWM_RESOLUTION-1:0] shadow_duty_q,  shadow_duty_d;
    logic                             shadow_dir_q,   shadow_dir_d;
    logic        [PWM_RESOLUTION-1:0] duty_active_q,  duty_active_d;
    logic                             dir_q,          dir_d;
    logic                             pwm_q,          pwm_d;
    logic                             period_start_q, period_start_d;
    logic                             dead_q,         dead_d;
    logic                             boundary;

    assign ctrl_in = bus.control_in;

    // Shadow capture: last strobe wins; disabling the driver discards the pending duty.
    always_comb begin
        shadow_duty_d = shadow_duty_q;
        shadow_dir_d  = shadow_dir_q;
        if (!bus.en) begin
            shadow_duty_d = '0;
        end else if (bus.control_valid) begin
            shadow_duty_d = PWM_RESOLUTION'(sat_abs(SAT_W'(ctrl_in), PWM_RESOLUTION));
            shadow_dir_d  = ctrl_in[CONTROL_WIDTH-1];
        end
    end

    // Next-state, counter, dead timer and output logic.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        dead_cnt_d     = dead_cnt_q;
        duty_active_d  = duty_active_q;
        dir_d          = dir_q;
        pwm_d          = 1'b0;
        period_start_d = 1'b0;
        dead_d         = 1'b0;

        // The boundary decision uses the shadow as it stood before this cycle's strobe.
        boundary = ((state_q == RUN) || (state_q == WAIT)) && (cnt_q == '0);

        if (!bus.en) begin
            state_d       = IDLE;
            cnt_d         = '0;
            dead_cnt_d    = '0;
            duty_active_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d       = RUN;
                    cnt_d         = '0;
                    dead_cnt_d    = '0;
                    duty_active_d = '0;
                end
                RUN, WAIT: begin
                    cnt_d = cnt_q + PWM_RESOLUTION'(1);
                    if (boundary) begin
                        // A zero duty never reverses the bridge.
                        if ((shadow_duty_q != '0) && (shadow_dir_q != dir_q)) begin
                            state_d       = DEAD;
                            dead_cnt_d    = '0;
                            duty_active_d = '0;
                        end else begin
                            state_d       = RUN;
                            duty_active_d = shadow_duty_q;
                        end
                    end
                end
                DEAD: begin
                    cnt_d = cnt_q + PWM_RESOLUTION'(1);
                    if (dead_cnt_q == DEAD_LAST) begin
                        state_d    = WAIT;
                        dir_d      = ~dir_q;
                        dead_cnt_d = '0;
                    end else begin
                        dead_cnt_d = dead_cnt_q + DEAD_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Compare against the duty taking effect this cycle so a new duty covers cnt==0.
        pwm_d          = (state_d == RUN) && (cnt_q < duty_active_d);
        period_start_d = (state_q != IDLE) && (cnt_q == '0);
        dead_d         = (state_d == DEAD);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            dead_cnt_q     <= '0;
            shadow_duty_q  <= '0;
            shadow_dir_q   <= 1'b0;
            duty_active_q  <= '0;
            dir_q          <= 1'b0;
            pwm_q          <= 1'b0;
            period_start_q <= 1'b0;
            dead_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            dead_cnt_q     <= dead_cnt_d;
            shadow_duty_q  <= shadow_duty_d;
            shadow_dir_q   <= shadow_dir_d;
            duty_active_q  <= duty_active_d;
            dir_q          <= dir_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
            dead_q         <= dead_d;
        end
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.dir_out      = dir_q;
    assign bus.period_start = period_start_q;
    assign bus.dead_active  = dead_q;
    assign bus.duty_active  = duty_active_q;

endmodule

// File: tb/tb_pwm_motor_driver.sv
// Directed + randomized bench for pwm_motor_driver with a cycle-level reference model.
module tb_pwm_motor_driver;

    localparam int unsigned RES    = 6;
    localparam int unsigned CW     = 7;
    localparam int unsigned DT     = 4;
    localparam int          PERIOD = 64;
    localparam int          DMAX   = 63;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    pwm_motor_driver_if #(.PWM_RESOLUTION(RES), .CONTROL_WIDTH(CW)) bus ();

    pwm_motor_driver #(
        .PWM_RESOLUTION (RES),
        .CONTROL_WIDTH  (CW),
        .DEADTIME_CYCLES(DT)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: position in period, applied duty/direction, pending command,
    // remaining dead-time cycles and a "hold low until boundary" flag.
    bit m_active;
    int m_cnt;
    int m_duty;
    bit m_dir;
    int m_sh_duty;
    bit m_sh_dir;
    int m_dead_left;
    bit m_hold;
    bit e_pwm;
    bit e_ps;
    bit e_dead;
    bit prev_dir;
    bit prev_dead;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int mag_sat(input int v);
        int a;
        a = (v < 0) ? -v : v;
        return (a > DMAX) ? DMAX : a;
    endfunction

    task automatic model_reset();
        m_active    = 1'b0;
        m_cnt       = 0;
        m_duty      = 0;
        m_dir       = 1'b0;
        m_sh_duty   = 0;
        m_sh_dir    = 1'b0;
        m_dead_left = 0;
        m_hold      = 1'b0;
        e_pwm       = 1'b0;
        e_ps        = 1'b0;
        e_dead      = 1'b0;
        prev_dir    = 1'b0;
        prev_dead   = 1'b0;
    endtask

    // Predict the outputs visible after the next clock edge given the current inputs.
    task automatic model_step(input bit en, input bit valid, input int ctrl);
        int nsd;
        bit nsdir;
        int pos;
        nsd   = m_sh_duty;
        nsdir = m_sh_dir;
        if (!en) begin
            nsd = 0;
        end else if (valid) begin
            nsd   = mag_sat(ctrl);
            nsdir = (ctrl < 0);
        end
        e_ps = m_active && (m_cnt == 0);
        pos  = m_cnt;
        if (!en) begin
            m_active    = 1'b0;
            m_cnt       = 0;
            m_duty      = 0;
            m_dead_left = 0;
            m_hold      = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_cnt    = 0;
            m_duty   = 0;
            m_hold   = 1'b0;
        end else begin
            if (m_dead_left > 0) begin
                m_dead_left = m_dead_left - 1;
                if (m_dead_left == 0) begin
                    m_dir  = !m_dir;
                    m_hold = 1'b1;
                end
            end else if (pos == 0) begin
                if (m_sh_duty != 0 && m_sh_dir != m_dir) begin
                    m_dead_left = DT;
                    m_duty      = 0;
                end else begin
                    m_duty = m_sh_duty;
                end
                m_hold = 1'b0;
            end
            m_cnt = (m_cnt + 1) % PERIOD;
        end
        e_dead    = (m_dead_left > 0);
        e_pwm     = m_active && !e_dead && !m_hold && (pos < m_duty);
        m_sh_duty = nsd;
        m_sh_dir  = nsdir;
    endtask

    // One clock: predict, advance, then compare every output plus the invariants.
    task automatic tick();
        model_step(bus.en, bus.control_valid, int'(bus.control_in));
        @(posedge clk);
        #1;
        bus.control_valid = 1'b0;
        chk("pwm_out",      32'(bus.pwm_out),      32'(e_pwm));
        chk("dir_out",      32'(bus.dir_out),      32'(m_dir));
        chk("period_start", 32'(bus.period_start), 32'(e_ps));
        chk("dead_active",  32'(bus.dead_active),  32'(e_dead));
        chk("duty_active",  32'(bus.duty_active),  32'(m_duty));
        chk("pwm_in_dead",  32'(bus.pwm_out & bus.dead_active), 32'(0));
        if (bus.dir_out != prev_dir) begin
            chk("dir_change_at_dead_end", 32'(prev_dead && !bus.dead_active), 32'(1));
        end
        prev_dir  = bus.dir_out;
        prev_dead = bus.dead_active;
    endtask

    task automatic strobe(input int v);
        bus.control_valid = 1'b1;
        bus.control_in    = 7'(v);
    endtask

    // Advance until the current cycle is a period boundary (counter at 0).
    task automatic run_to_boundary();
        int n;
        n = 0;
        tick();
        while (m_cnt != 0 && n < 200) begin
            tick();
            n++;
        end
    endtask

    // Starting on a boundary cycle, observe one full period.
    task automatic window(output int pwm_hi, output int dead_hi);
        pwm_hi  = 0;
        dead_hi = int'(bus.dead_active);
        for (int i = 0; i < PERIOD; i++) begin
            tick();
            pwm_hi += int'(bus.pwm_out);
            if (i < PERIOD - 1) dead_hi += int'(bus.dead_active);
        end
    endtask

    initial begin
        int p;
        int d;
        int v;
        int n;
        int off_left;

        reset_n           = 1'b0;
        bus.en            = 1'b1;
        bus.control_valid = 1'b0;
        bus.control_in    = '0;
        model_reset();

        // 1: reset held with enable and strobes active
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            strobe(20);
            chk("rst_pwm",   32'(bus.pwm_out),      32'(0));
            chk("rst_dir",   32'(bus.dir_out),      32'(0));
            chk("rst_ps",    32'(bus.period_start), 32'(0));
            chk("rst_dead",  32'(bus.dead_active),  32'(0));
            chk("rst_duty",  32'(bus.duty_active),  32'(0));
        end
        bus.control_valid = 1'b0;
        reset_n = 1'b1;
        tick();
        chk("ps_not_yet", 32'(bus.period_start), 32'(0));
        tick();
        chk("ps_first_pulse", 32'(bus.period_start), 32'(1));
        tick();
        chk("ps_single_cycle", 32'(bus.period_start), 32'(0));

        // 2: +16 strobed mid-period, applied at the boundary
        for (int i = 0; i < 10; i++) tick();
        strobe(16);
        tick();
        chk("t2_duty_held", 32'(bus.duty_active), 32'(0));
        run_to_boundary();
        window(p, d);
        chk("t2_pwm_hi", 32'(p), 32'(16));
        chk("t2_duty", 32'(bus.duty_active), 32'(16));
        chk("t2_dir", 32'(bus.dir_out), 32'(0));
        window(p, d);
        chk("t2_pwm_hi_2", 32'(p), 32'(16));

        // 3: reversal to most-negative command
        for (int i = 0; i < 5; i++) tick();
        strobe(-64);
        tick();
        run_to_boundary();
        window(p, d);
        chk("t3_dead_cycles", 32'(d), 32'(DT));
        chk("t3_pwm_hi_dead_period", 32'(p), 32'(0));
        chk("t3_dir", 32'(bus.dir_out), 32'(1));
        window(p, d);
        chk("t3_pwm_hi_sat", 32'(p), 32'(63));
        chk("t3_duty_sat", 32'(bus.duty_active), 32'(63));

        // 4: zero command in reverse, then a strobe on the boundary cycle
        for (int i = 0; i < 7; i++) tick();
        strobe(0);
        tick();
        run_to_boundary();
        window(p, d);
        chk("t4_pwm_hi_zero", 32'(p), 32'(0));
        chk("t4_no_dead", 32'(d), 32'(0));
        chk("t4_dir_kept", 32'(bus.dir_out), 32'(1));
        strobe(-20);
        window(p, d);
        chk("t4_boundary_strobe_deferred", 32'(p), 32'(0));
        window(p, d);
        chk("t4_boundary_strobe_applied", 32'(p), 32'(20));

        // 5: enable dropped mid-period
        for (int i = 0; i < 9; i++) tick();
        bus.en = 1'b0;
        tick();
        chk("t5_pwm_off", 32'(bus.pwm_out), 32'(0));
        chk("t5_duty_off", 32'(bus.duty_active), 32'(0));
        chk("t5_dir_kept", 32'(bus.dir_out), 32'(1));
        for (int i = 0; i < 3; i++) tick();
        chk("t5_ps_idle", 32'(bus.period_start), 32'(0));
        bus.en = 1'b1;
        p = 0;
        for (int i = 0; i < 130; i++) begin
            tick();
            p += int'(bus.pwm_out);
        end
        chk("t5_pwm_low_after_en", 32'(p), 32'(0));
        strobe(-10);
        tick();
        run_to_boundary();
        window(p, d);
        chk("t5_pwm_hi_new", 32'(p), 32'(10));

        // 6: asynchronous reset in the middle of dead time
        strobe(30);
        tick();
        n = 0;
        while (!bus.dead_active && n < 200) begin
            tick();
            n++;
        end
        chk("t6_dead_reached", 32'(bus.dead_active), 32'(1));
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_pwm",  32'(bus.pwm_out),      32'(0));
        chk("t6_async_dir",  32'(bus.dir_out),      32'(0));
        chk("t6_async_ps",   32'(bus.period_start), 32'(0));
        chk("t6_async_dead", 32'(bus.dead_active),  32'(0));
        chk("t6_async_duty", 32'(bus.duty_active),  32'(0));
        model_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        tick();
        chk("t6_dir_after", 32'(bus.dir_out), 32'(0));
        chk("t6_ps_after", 32'(bus.period_start), 32'(1));

        // Randomized commands with occasional enable drops
        off_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!bus.en) begin
                if (off_left == 0) bus.en = 1'b1;
                else off_left--;
            end else if ($urandom_range(199) == 0) begin
                bus.en   = 1'b0;
                off_left = int'($urandom_range(4));
            end
            if ($urandom_range(24) == 0) begin
                v = int'($urandom_range(127)) - 64;
                strobe(v);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
